// File: rtl/hex_window_scanner.sv
// Scans a NUM_DIGITS-wide strip of the world cell store, decodes each cell through the
// external 7-seg decoder and commits all digits to hex_flat on one edge. Optional: SCAN_TIMEOUT_EN.
module hex_window_scanner #(
  parameter int NUM_DIGITS     = 8,
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 16,
  parameter int REFRESH_CYCLES = 500000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [$clog2(GRID_W)-1:0]             win_x,
  input  logic [$clog2(GRID_H)-1:0]             win_y,
  input  logic                                  scan_now,
  output logic                                  rd_req,
  output logic [$clog2(GRID_W*GRID_H)-1:0]      rd_addr,
  input  logic                                  rd_valid,
  input  logic [4:0]                            rd_data,
  output logic [4:0]                            cell_code,
  input  logic [6:0]                            seg_in,
  output logic [7*NUM_DIGITS-1:0]               hex_flat,
  output logic                                  busy,
  output logic                                  frame_done
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, LATCH, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [XW-1:0]           ox_q, ox_d;
  logic [YW-1:0]           oy_q, oy_d;
  logic [4:0]              code_q, code_d;
  logic [7*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [XW-1:0]           col;
`ifdef SCAN_TIMEOUT_EN
  logic [7:0]              tmo_q, tmo_d;
`endif

  // Column wraps modulo GRID_W because the sum is truncated to XW bits; row stays fixed.
  assign col        = ox_q + XW'(idx_q);
  assign rd_addr    = {oy_q, col};
  assign rd_req     = (state_q == REQ);
  assign cell_code  = code_q;
  assign hex_flat   = hex_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == COMMIT);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
`ifdef SCAN_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (scan_now || cnt_q == CW'(REFRESH_CYCLES - 1)) begin
          state_d = REQ;
          idx_d   = '0;
          cnt_d   = '0;
          ox_d    = win_x;
          oy_d    = win_y;
`ifdef SCAN_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REQ: begin
        if (rd_valid) begin
          code_d  = rd_data;
          state_d = LATCH;
        end
`ifdef SCAN_TIMEOUT_EN
        else if (tmo_q == 8'd254) begin
          // 255th silent cycle: mark the digit with the error glyph and move on.
          shadow_d[int'(idx_q)*7 +: 7] = 7'b0110110;
          tmo_d = '0;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            state_d = COMMIT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = REQ;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      LATCH: begin
        shadow_d[int'(idx_q)*7 +: 7] = seg_in;
`ifdef SCAN_TIMEOUT_EN
        tmo_d = '0;
`endif
        if (idx_q == IW'(NUM_DIGITS - 1)) begin
          state_d = COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = REQ;
        end
      end
      COMMIT: begin
        hex_d   = shadow_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      code_q  <= '0;
      hex_q   <= '1;
`ifdef SCAN_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      code_q  <= code_d;
      hex_q   <= hex_d;
`ifdef SCAN_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // NOTE: the shadow buffer has no reset; every entry is rewritten before a commit can read it.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule
